mdu_sequencer: RTL and testbench

Multi-cycle unsigned multiply/divide sequencer that borrows the shared 32-bit ALU to execute MULTU and DIVU iteratively, one ALU operation per cycle. It also provides MTHI/MTLO writes and holds the architectural HI/LO registers. It sits beside the EX stage. While `busy` is high it owns the ALU through `alu_sel`; the datapath muxes `alu_a`/`alu_b`/`alu_op` onto the ALU inputs and returns the ALU result on `alu_c`.

---
 rtl/mdu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative unsigned MULTU/DIVU sequencer that borrows the shared ALU one op per cycle.
// Also owns the architectural HI/LO registers and services MTHI/MTLO.
module mdu_sequencer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         alu_sel,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_c
);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [5:0] LAST_CNT = 6'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    // acc holds P_hi or R, shf holds P_lo or Q, opnd holds M or D
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] shf_q, shf_d;
    logic [W-1:0] opnd_q, opnd_d;

    logic [W-1:0] div_t;
    logic         carry;
    logic         borrow;
    logic         qbit;

    assign div_t = {acc_q[W-2:0], shf_q[W-1]};

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        case (state_q)
            S_MUL: begin
                alu_a  = acc_q;
                alu_b  = shf_q[0] ? opnd_q : '0;
                alu_op = ALU_ADD;
            end
            S_DIV: begin
                alu_a  = div_t;
                alu_b  = opnd_q;
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    // Carry-out and borrow recovered from the sign bits since the ALU only returns W bits
    assign carry  = (alu_a[W-1] & alu_b[W-1]) | ((alu_a[W-1] | alu_b[W-1]) & ~alu_c[W-1]);
    assign borrow = (~alu_a[W-1] & alu_b[W-1]) | (~(alu_a[W-1] ^ alu_b[W-1]) & alu_c[W-1]);
    assign qbit   = acc_q[W-1] | ~borrow;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        shf_d   = shf_q;
        opnd_d  = opnd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            acc_d   = '0;
                            shf_d   = rt_val;
                            opnd_d  = rs_val;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = S_MUL;
                        end
                        OP_DIVU: begin
                            acc_d   = '0;
                            shf_d   = rs_val;
                            opnd_d  = rt_val;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {carry, alu_c[W-1:1]};
                shf_d = {alu_c[0], shf_q[W-1:1]};
            end
            S_DIV: begin
                acc_d = qbit ? alu_c : div_t;
                shf_d = {shf_q[W-2:0], qbit};
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            if (cnt_q == LAST_CNT) begin
                hi_d    = acc_d;
                lo_d    = shf_d;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            shf_q   <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            shf_q   <= shf_d;
            opnd_q  <= opnd_d;
        end
    end

    assign busy    = busy_q;
    assign alu_sel = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed plan cases plus random MULTU/DIVU
// against an arithmetic reference model, with a behavioural ALU closing the loop.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    mdu_sequencer #(.W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .alu_sel (alu_sel),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_c   (alu_c)
    );

    assign alu_c = (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference results straight from unsigned arithmetic
    task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        if (mop == 2'b00) begin
            prod   = {32'h0, a} * {32'h0, b};
            exp_hi = prod[63:32];
            exp_lo = prod[31:0];
        end else if (b == 32'h0) begin
            exp_hi = a;
            exp_lo = 32'hFFFF_FFFF;
        end else begin
            exp_hi = a % b;
            exp_lo = a / b;
        end
    endtask

    // Issue MULTU/DIVU at the current negedge; returns at the first negedge with busy low.
    // inject_at > 0 pulses an MTLO 0x1234 at that busy cycle, which must be ignored.
    task automatic run_seq(input string tag, input logic [1:0] mop, input logic [31:0] a,
                           input logic [31:0] b, input int inject_at);
        int n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = exp_hi;
        old_lo = exp_lo;
        start  = 1'b1;
        op     = mop;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 1 || n == 16) begin
                check({tag, " alu_sel"}, {31'h0, alu_sel}, 32'h1);
                check({tag, " hold hi"}, hi, old_hi);
                check({tag, " hold lo"}, lo, old_lo);
            end
            if (n == inject_at) begin
                start  = 1'b1;
                op     = 2'b11;
                rs_val = 32'h0000_1234;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        model(mop, a, b);
        check({tag, " busy cycles"}, n, 32);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " idle alu_sel"}, {31'h0, alu_sel}, 32'h0);
    endtask

    task automatic run_mt(input string tag, input logic [1:0] mop, input logic [31:0] a);
        start  = 1'b1;
        op     = mop;
        rs_val = a;
        rt_val = 32'h0;
        @(negedge clk);
        start = 1'b0;
        if (mop == 2'b10) exp_hi = a;
        else exp_lo = a;
        check({tag, " busy"}, {31'h0, busy}, 32'h0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = 32'h0;
        rt_val = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset alu_sel", {31'h0, alu_sel}, 32'h0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset alu_a", alu_a, 32'h0);
        check("reset alu_b", alu_b, 32'h0);
        check("reset alu_op", {29'h0, alu_op}, 32'h0);

        run_seq("mul ffff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul ffff const hi", hi, 32'hFFFF_FFFE);
        check("mul ffff const lo", lo, 32'h0000_0001);

        run_seq("div 100/7", 2'b01, 32'd100, 32'd7, 0);
        check("div 100/7 const hi", hi, 32'd2);
        check("div 100/7 const lo", lo, 32'd14);
        run_seq("div 8000/3", 2'b01, 32'h8000_0000, 32'd3, 0);
        check("div 8000/3 const lo", lo, 32'h2AAA_AAAA);
        run_seq("div by 0", 2'b01, 32'h1234_5678, 32'h0, 0);
        check("div by 0 const lo", lo, 32'hFFFF_FFFF);

        run_mt("mthi", 2'b10, 32'hDEAD_BEEF);
        run_mt("mtlo", 2'b11, 32'h0000_CAFE);
        run_seq("mul 3x5", 2'b00, 32'd3, 32'd5, 0);
        check("mul 3x5 const lo", lo, 32'd15);

        run_seq("mul ignore start", 2'b00, 32'h0001_0003, 32'h0000_0101, 5);
        run_seq("div back2back", 2'b01, 32'hCAFE_F00D, 32'h0000_0123, 0);

        // Abort a DIVU with reset at busy cycle 10
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'h7777_7777;
        rt_val = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-reset busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort alu_sel", {31'h0, alu_sel}, 32'h0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        check("abort alu_op", {29'h0, alu_op}, 32'h0);
        run_seq("mul 7x6", 2'b00, 32'd7, 32'd6, 0);

        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 3 == 1) rb = rb >> $urandom_range(8, 31);
            run_seq("random", rop, ra, rb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
